// File: rtl/tmr_err_monitor.sv
// tmr_err_monitor
// Takes the err output of a TMR voter and converts it into system status:
// rising-edge fault events, a saturating lifetime fault count, a sticky
// flag, and a windowed-rate alarm that software clears.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   err_in       voter error level (may stay high for many cycles)
//   clr          single-cycle clear of count, sticky, alarm and window
//   o_err_pulse  one-cycle pulse per fault event
//   o_fault_cnt  lifetime fault events since reset/clr, saturating
//   o_sticky     set by any event, held until clr
//   o_alarm      THRESH events seen within one WINDOW, held until clr
//   o_state      FSM state for debug (0 IDLE, 1 WIN, 2 ALARM)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no window open, waiting for the first event
// WIN   | window open, timer running, counting events toward THRESH
// ALARM | threshold reached; window frozen until clr or rst

module tmr_err_monitor #(
    parameter int CNT_WIDTH = 8,
    parameter int THRESH    = 4,
    parameter int WINDOW    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 err_in,
    input  logic                 clr,
    output logic                 o_err_pulse,
    output logic [CNT_WIDTH-1:0] o_fault_cnt,
    output logic                 o_sticky,
    output logic                 o_alarm,
    output logic [1:0]           o_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WIN   = 2'd1;
    localparam logic [1:0] S_ALARM = 2'd2;

    localparam int TW = (WINDOW > 2) ? $clog2(WINDOW) : 1;

    localparam logic [TW-1:0]        WIN_LAST = TW'(WINDOW - 1);
    localparam logic [CNT_WIDTH-1:0] THRESH_V = CNT_WIDTH'(THRESH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    logic                 err_q, err_d;
    logic                 pulse_q, pulse_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;
    logic                 alarm_q, alarm_d;
    logic [1:0]           state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    // win_cnt never exceeds THRESH, which is bounded by the counter range
    logic [CNT_WIDTH-1:0] win_q, win_d;

    logic                 ev;
    logic [CNT_WIDTH-1:0] cnt_b, win_b, win_nxt;
    logic                 sticky_b;
    logic [1:0]           state_b;
    logic [TW-1:0]        timer_b;

    always_comb begin
        ev      = err_in & ~err_q;
        err_d   = err_in;
        pulse_d = ev;

        // clr is applied first; a same-edge event then lands on the cleared state
        if (clr) begin
            cnt_b    = '0;
            sticky_b = 1'b0;
            state_b  = S_IDLE;
            win_b    = '0;
            timer_b  = '0;
        end else begin
            cnt_b    = cnt_q;
            sticky_b = sticky_q;
            state_b  = state_q;
            win_b    = win_q;
            timer_b  = timer_q;
        end

        cnt_d = cnt_b;
        if (ev && (cnt_b != CNT_MAX)) begin
            cnt_d = cnt_b + ONE;
        end
        sticky_d = sticky_b | ev;

        state_d = state_b;
        win_d   = win_b;
        timer_d = timer_b;
        win_nxt = win_b + ONE;

        case (state_b)
            S_IDLE: begin
                if (ev) begin
                    timer_d = '0;
                    win_d   = ONE;
                    state_d = (THRESH == 1) ? S_ALARM : S_WIN;
                end
            end
            S_WIN: begin
                timer_d = timer_b + 1'b1;
                // threshold wins over expiry on the same edge
                if (ev && (win_nxt >= THRESH_V)) begin
                    state_d = S_ALARM;
                    win_d   = win_nxt;
                    timer_d = timer_b;
                end else if (timer_b == WIN_LAST) begin
                    timer_d = '0;
                    if (ev) begin
                        win_d = ONE;
                    end else begin
                        state_d = S_IDLE;
                        win_d   = '0;
                    end
                end else if (ev) begin
                    win_d = win_nxt;
                end
            end
            S_ALARM: begin
                // window progress frozen until clr/rst
            end
            default: begin
                state_d = S_IDLE;
                win_d   = '0;
                timer_d = '0;
            end
        endcase

        alarm_d = (state_d == S_ALARM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q    <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            alarm_q  <= 1'b0;
            state_q  <= S_IDLE;
            timer_q  <= '0;
            win_q    <= '0;
        end else begin
            err_q    <= err_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            alarm_q  <= alarm_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
            win_q    <= win_d;
        end
    end

    assign o_err_pulse = pulse_q;
    assign o_fault_cnt = cnt_q;
    assign o_sticky    = sticky_q;
    assign o_alarm     = alarm_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_tmr_err_monitor.sv
// Directed testbench for tmr_err_monitor. A default instance (CNT_WIDTH=8,
// THRESH=4, WINDOW=16) covers the event/window/alarm/clear behaviour and a
// CNT_WIDTH=3 instance covers counter saturation and mid-window reset.
// Outputs are sampled 1 time unit after each rising edge.

module tb_tmr_err_monitor;

    logic       clk = 1'b0;
    logic       rst, err_in, clr;
    logic       o_err_pulse, o_sticky, o_alarm;
    logic [7:0] o_fault_cnt;
    logic [1:0] o_state;

    logic       s_rst, s_err, s_clr;
    logic       s_pulse, s_sticky, s_alarm;
    logic [2:0] s_cnt;
    logic [1:0] s_state;

    int vectors = 0;
    int miscompares = 0;

    wire [12:0] obs   = {o_err_pulse, o_fault_cnt, o_sticky, o_alarm, o_state};
    wire [7:0]  s_obs = {s_pulse, s_cnt, s_sticky, s_alarm, s_state};

    always #5 clk = ~clk;

    tmr_err_monitor #(.CNT_WIDTH(8), .THRESH(4), .WINDOW(16)) dut (
        .clk(clk), .rst(rst), .err_in(err_in), .clr(clr),
        .o_err_pulse(o_err_pulse), .o_fault_cnt(o_fault_cnt),
        .o_sticky(o_sticky), .o_alarm(o_alarm), .o_state(o_state)
    );

    tmr_err_monitor #(.CNT_WIDTH(3), .THRESH(4), .WINDOW(16)) dut_s (
        .clk(clk), .rst(s_rst), .err_in(s_err), .clr(s_clr),
        .o_err_pulse(s_pulse), .o_fault_cnt(s_cnt),
        .o_sticky(s_sticky), .o_alarm(s_alarm), .o_state(s_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {pulse, cnt[7:0], sticky, alarm, state[1:0]}
    task automatic test_reset();
        rst = 1'b1; err_in = 1'b0; clr = 1'b0;
        tick(); tick();
        if (obs !== 13'd0) begin
            $display("FAIL reset: got %b exp %b", obs, 13'd0);
            miscompares++;
        end
        vectors++;
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (obs !== 13'd0) begin
                $display("FAIL idle cyc %0d: got %b exp %b", i, obs, 13'd0);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_long_fault();
        logic [12:0] exp;
        err_in = 1'b1;
        tick();
        exp = {1'b1, 8'd1, 1'b1, 1'b0, 2'd1};
        if (obs !== exp) begin
            $display("FAIL long_fault first: got %b exp %b", obs, exp);
            miscompares++;
        end
        vectors++;
        exp = {1'b0, 8'd1, 1'b1, 1'b0, 2'd1};
        for (int i = 2; i <= 16; i++) begin
            if (i == 11) err_in = 1'b0;
            tick();
            if (obs !== exp) begin
                $display("FAIL long_fault win cyc %0d: got %b exp %b", i, obs, exp);
                miscompares++;
            end
            vectors++;
        end
        tick();
        exp = {1'b0, 8'd1, 1'b1, 1'b0, 2'd0};
        if (obs !== exp) begin
            $display("FAIL long_fault expiry: got %b exp %b", obs, exp);
            miscompares++;
        end
        vectors++;
        clr = 1'b1; tick(); clr = 1'b0;
        if (obs !== 13'd0) begin
            $display("FAIL long_fault clr: got %b exp %b", obs, 13'd0);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_burst_alarm();
        logic [12:0] exp;
        for (int e = 1; e <= 4; e++) begin
            err_in = 1'b1;
            tick();
            exp = {1'b1, 8'(e), 1'b1, (e == 4), (e == 4) ? 2'd2 : 2'd1};
            if (obs !== exp) begin
                $display("FAIL burst event %0d: got %b exp %b", e, obs, exp);
                miscompares++;
            end
            vectors++;
            err_in = 1'b0;
            tick(); tick();
        end
        for (int e = 5; e <= 9; e++) begin
            err_in = 1'b1;
            tick();
            exp = {1'b1, 8'(e), 1'b1, 1'b1, 2'd2};
            if (obs !== exp) begin
                $display("FAIL burst extra %0d: got %b exp %b", e, obs, exp);
                miscompares++;
            end
            vectors++;
            err_in = 1'b0;
            tick();
            exp = {1'b0, 8'(e), 1'b1, 1'b1, 2'd2};
            if (obs !== exp) begin
                $display("FAIL burst hold %0d: got %b exp %b", e, obs, exp);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_clr_event();
        logic [12:0] exp;
        err_in = 1'b1; clr = 1'b1;
        tick();
        err_in = 1'b0; clr = 1'b0;
        exp = {1'b1, 8'd1, 1'b1, 1'b0, 2'd1};
        if (obs !== exp) begin
            $display("FAIL clr_event: got %b exp %b", obs, exp);
            miscompares++;
        end
        vectors++;
        repeat (15) tick();
        exp = {1'b0, 8'd1, 1'b1, 1'b0, 2'd1};
        if (obs !== exp) begin
            $display("FAIL clr_event win end: got %b exp %b", obs, exp);
            miscompares++;
        end
        vectors++;
        tick();
        exp = {1'b0, 8'd1, 1'b1, 1'b0, 2'd0};
        if (obs !== exp) begin
            $display("FAIL clr_event expiry: got %b exp %b", obs, exp);
            miscompares++;
        end
        vectors++;
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_window_expiry();
        logic [12:0] exp;
        for (int t = 1; t <= 27; t++) begin
            err_in = (t == 1 || t == 3 || t == 5 || t == 21 || t == 23 || t == 25 || t == 27);
            tick();
            exp = obs;
            case (t)
                1:  exp = {1'b1, 8'd1, 1'b1, 1'b0, 2'd1};
                16: exp = {1'b0, 8'd3, 1'b1, 1'b0, 2'd1};
                17: exp = {1'b0, 8'd3, 1'b1, 1'b0, 2'd0};
                21: exp = {1'b1, 8'd4, 1'b1, 1'b0, 2'd1};
                25: exp = {1'b1, 8'd6, 1'b1, 1'b0, 2'd1};
                27: exp = {1'b1, 8'd7, 1'b1, 1'b1, 2'd2};
                default: ;
            endcase
            if (t == 1 || t == 16 || t == 17 || t == 21 || t == 25 || t == 27) begin
                if (obs !== exp) begin
                    $display("FAIL window_expiry t=%0d: got %b exp %b", t, obs, exp);
                    miscompares++;
                end
                vectors++;
            end
        end
        err_in = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_expiry_edge();
        logic [12:0] exp;
        // threshold reached on the expiry edge -> alarm
        for (int t = 1; t <= 17; t++) begin
            err_in = (t == 1 || t == 3 || t == 5 || t == 17);
            tick();
            if (t == 16) begin
                exp = {1'b0, 8'd3, 1'b1, 1'b0, 2'd1};
                if (obs !== exp) begin
                    $display("FAIL edge_thresh pre: got %b exp %b", obs, exp);
                    miscompares++;
                end
                vectors++;
            end
        end
        exp = {1'b1, 8'd4, 1'b1, 1'b1, 2'd2};
        if (obs !== exp) begin
            $display("FAIL edge_thresh: got %b exp %b", obs, exp);
            miscompares++;
        end
        vectors++;
        err_in = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        // event on expiry edge below threshold -> fresh window
        for (int t = 1; t <= 33; t++) begin
            err_in = (t == 1 || t == 17);
            tick();
            if (t == 17 || t == 32 || t == 33) begin
                exp = {(t == 17), 8'd2, 1'b1, 1'b0, (t == 33) ? 2'd0 : 2'd1};
                if (obs !== exp) begin
                    $display("FAIL edge_fresh t=%0d: got %b exp %b", t, obs, exp);
                    miscompares++;
                end
                vectors++;
            end
        end
        err_in = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    // {pulse, cnt[2:0], sticky, alarm, state[1:0]} on the narrow instance
    task automatic test_saturation();
        logic [7:0] exp;
        s_rst = 1'b1; s_err = 1'b1; s_clr = 1'b0;
        tick();
        if (s_obs !== 8'd0) begin
            $display("FAIL sat reset: got %b exp %b", s_obs, 8'd0);
            miscompares++;
        end
        vectors++;
        s_rst = 1'b0;
        tick();
        exp = {1'b1, 3'd1, 1'b1, 1'b0, 2'd1};
        if (s_obs !== exp) begin
            $display("FAIL sat first edge: got %b exp %b", s_obs, exp);
            miscompares++;
        end
        vectors++;
        s_err = 1'b0;
        for (int k = 2; k <= 10; k++) begin
            repeat (19) tick();
            s_err = 1'b1;
            tick();
            s_err = 1'b0;
            exp = {1'b1, (k > 7) ? 3'd7 : 3'(k), 1'b1, 1'b0, 2'd1};
            if (s_obs !== exp) begin
                $display("FAIL sat event %0d: got %b exp %b", k, s_obs, exp);
                miscompares++;
            end
            vectors++;
        end
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        if (s_obs !== 8'd0) begin
            $display("FAIL sat midwin rst: got %b exp %b", s_obs, 8'd0);
            miscompares++;
        end
        vectors++;
    endtask

    initial begin
        s_rst = 1'b1; s_err = 1'b0; s_clr = 1'b0;
        test_reset();
        test_long_fault();
        test_burst_alarm();
        test_clr_event();
        test_window_expiry();
        test_expiry_edge();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
